// File: rtl/stf_sequencer.sv
// stf_sequencer: streams NUM_REP repetitions of the 16-entry STF ROM over valid/ready,
// optionally halving the very first sample as the overlap window.
module stf_sequencer #(
  parameter int NUM_REP   = 10,
  parameter bit WINDOW_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        abort,
  output logic [3:0]  rom_addr,
  input  logic [31:0] rom_dout,
  output logic [31:0] m_iq,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t      state_q, state_d;
  logic [3:0]  addr_q, addr_d, rep_q, rep_d;
  logic [31:0] iq_q, iq_d, win_iq;
  logic        valid_q, valid_d, last_q, last_d, busy_q, busy_d, done_q, done_d;
  logic        slot_free, is_last, win;
  assign slot_free = !valid_q || m_ready;
  assign is_last   = rep_q == 4'(NUM_REP - 1) && addr_q == 4'd15;
  assign win       = WINDOW_EN && rep_q == 4'd0 && addr_q == 4'd0;
  // arithmetic shift of each 16-bit half: replicate the half's sign bit
  assign win_iq    = {rom_dout[31], rom_dout[31:17], rom_dout[15], rom_dout[15:1]};
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rep_d   = rep_q;
    iq_d    = iq_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = IDLE;
      addr_d  = 4'd0;
      rep_d   = 4'd0;
      valid_d = 1'b0;
      last_d  = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_d = RUN;
          addr_d  = 4'd0;
          rep_d   = 4'd0;
          busy_d  = 1'b1;
        end
        RUN: if (slot_free) begin
          iq_d    = win ? win_iq : rom_dout;
          valid_d = 1'b1;
          last_d  = is_last;
          addr_d  = addr_q + 4'd1;
          rep_d   = addr_q == 4'd15 ? rep_q + 4'd1 : rep_q;
          state_d = is_last ? FLUSH : RUN;
        end
        FLUSH: if (valid_q && m_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      addr_q  <= 4'd0;
      rep_q   <= 4'd0;
      iq_q    <= 32'd0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rep_q   <= rep_d;
      iq_q    <= iq_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign rom_addr = addr_q;
  assign m_iq     = iq_q;
  assign m_valid  = valid_q;
  assign m_last   = last_q;
  assign busy     = busy_q;
  assign done     = done_q;
endmodule

// File: doc/stf_sequencer.md
Name: stf_sequencer

Overview:
- Controller that sequences the 16-entry short-training-field (STF) ROM to produce the complete 802.11a/g short preamble as a sample stream.
- Sits in openofdm_tx between the TX control FSM, which issues start, and the preamble/data mux, which consumes the stream.
- Drives the ROM address and reads the ROM output combinationally.
- Emits NUM_REP repetitions of the 16 samples over a valid/ready interface, with optional half-amplitude windowing on the first sample.

Parameters:
- NUM_REP, 10, number of 16-sample repetitions per preamble (legal range 1..15).
- WINDOW_EN, 1, when 1 the first emitted sample is scaled by 0.5 (802.11 overlap window).

Ports:
- clk  input  1  system clock.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse that requests one preamble; ignored while busy=1.
- abort  input  1  synchronous cancel; priority over everything except reset.
- rom_addr  output  4  address to the STF ROM; combinational from the internal address counter.
- rom_dout  input  32  ROM sample, valid in the same cycle as rom_addr; [31:16]=I, [15:0]=Q, each signed 16-bit.
- m_iq  output  32  registered output sample, same packing as rom_dout.
- m_valid  output  1  m_iq holds a valid sample.
- m_ready  input  1  downstream accepts m_iq when m_valid&m_ready.
- m_last  output  1  high with the final sample (rep NUM_REP-1, addr 15).
- busy  output  1  high from the cycle after start until done.
- done  output  1  single-cycle pulse after the last sample is accepted.

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE; addr_cnt=0; rep_cnt=0; m_iq=0; m_valid=0; m_last=0; busy=0; done=0.
- Internal state:
  - addr_cnt is 4 bits and wraps 15->0.
  - rep_cnt is 4 bits and increments on each addr_cnt wrap.
  - rom_addr=addr_cnt at all times.
- slot_free = !m_valid | m_ready.
- FSM states: IDLE, RUN, FLUSH.
- IDLE:
  - On start=1, go to RUN with addr_cnt=0, rep_cnt=0, busy=1.
  - m_valid stays 0 in the start cycle.
- RUN:
  - Each cycle with slot_free=1, load the sample:
    - m_iq <= rom_dout (windowed if applicable); m_valid <= 1.
    - m_last <= (rep_cnt==NUM_REP-1 && addr_cnt==15).
    - addr_cnt++.
  - When the loaded sample is the last one, go to FLUSH.
  - Each cycle with slot_free=0, hold m_iq, m_valid, m_last and the counters unchanged.
- Latency: the first sample appears (m_valid=1) in the 2nd cycle after the start pulse. With m_ready tied to 1, the stream is gap-free: 16*NUM_REP consecutive valid cycles.
- FLUSH:
  - When m_valid&m_ready, set m_valid<=0, m_last<=0, done<=1 for 1 cycle, busy<=0, and go to IDLE.
  - done is asserted in the cycle after the last handshake.
- Windowing applies when WINDOW_EN=1 and the sample is rep 0, addr 0 only.
  - I and Q are each arithmetic-shifted right by 1 (sign-preserving, truncation toward -inf).
  - No other sample is modified.
- start while busy=1 is ignored; no restart and no queueing.
- start coincident with done (in IDLE the following cycle) is accepted normally.
- abort=1 in any state takes effect at the next clock edge:
  - state=IDLE; m_valid=0; m_last=0; busy=0; counters=0.
  - done is not pulsed.
  - An abort in the same cycle as start leaves the block in IDLE.
- m_iq holds its last value while m_valid=0; downstream must not sample it.
- Asynchronous reset mid-preamble returns the block to reset values immediately, with no done.

Test Plan:
- Reset, start pulse, m_ready=1, NUM_REP=10, WINDOW_EN=1:
  - first m_iq=0x02F102F1;
  - second=0xEF0C004D;
  - 5th=0x0BC70000, 13th=0x00000BC7;
  - exactly 160 valid cycles, m_last on the 160th only;
  - done one cycle later; busy low after.
- WINDOW_EN=0: first sample=0x05E305E3; 17th sample (rep 1, addr 0)=0x05E305E3, unwindowed.
- Randomized m_ready backpressure (50% duty): every sample is held stable while m_valid&!m_ready; the 160 accepted samples match the ROM sequence in order; total accepted=160.
- Negative-value windowing check: force rom_dout=0xEF0CFFFF at rep0/addr0 -> m_iq=0xF786FFFF.
- Abort at the 37th accepted sample: m_valid=0 next cycle, busy=0, no done; a following start restarts from the windowed sample at addr 0.
- Second start pulse at cycle 50 while busy: ignored, still exactly 160 samples. A start on the cycle after done: a new preamble begins normally.
